// File: rtl/pupil_detect_param.sv
// Pupil detector for the Stonyman capture path. Each row is scanned at one
// pixel per clock. The block keeps the longest pupil-pixel run found in the
// frame and reports its centre, row and width when the frame ends.
module pupil_detect_param #(
   parameter int unsigned RESOLUTION = 112,
   parameter int unsigned PIX_W      = 8,
   parameter int unsigned COORD_W    = 8,
   parameter int unsigned POLARITY   = 1,
   parameter int unsigned MIN_RUN    = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [RESOLUTION*PIX_W-1:0]   row_pixels,
   input  logic                          row_valid,
   output logic                          row_ready,
   input  logic                          frame_capture_done,
   input  logic [PIX_W-1:0]              threshold,
   output logic [COORD_W-1:0]            pupil_location_horizontal,
   output logic [COORD_W-1:0]            pupil_location_vertical,
   output logic [COORD_W-1:0]            pupil_width,
   output logic                          pupil_found,
   output logic                          result_valid
);

   localparam int unsigned ROW_W = RESOLUTION * PIX_W;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SCAN    = 2'd1;
   localparam logic [1:0] S_PUBLISH = 2'd2;

   localparam logic [COORD_W-1:0] LAST_IDX = COORD_W'(RESOLUTION - 1);
   localparam logic [COORD_W-1:0] MIN_LEN  = COORD_W'(MIN_RUN);
   localparam logic [COORD_W-1:0] ROW_MAX  = '1;
   localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

   logic [1:0]         state, state_n;
   logic [ROW_W-1:0]   row_buf;
   logic [PIX_W-1:0]   thr;
   logic [COORD_W-1:0] pixel_idx;
   logic [COORD_W-1:0] run_len, run_start;
   logic [COORD_W-1:0] row_best_len, row_best_start;
   logic [COORD_W-1:0] frame_best_len, frame_best_start, frame_best_row;
   logic [COORD_W-1:0] row_idx;
   logic               pending;

   logic [PIX_W-1:0]   pix;
   logic               is_pupil;
   logic               last_pix;
   logic [COORD_W-1:0] run_len_inc, start_ext;
   logic [COORD_W-1:0] cl_len, cl_start;
   logic [COORD_W-1:0] rb_len_n, rb_start_n;
   logic               frame_upd;
   logic [COORD_W-1:0] pub_len, pub_start, pub_row, pub_center;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state decode
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (row_valid)               state_n = S_SCAN;
            else if (frame_capture_done) state_n = S_PUBLISH;
         end
         S_SCAN: begin
            if (last_pix) state_n = (pending || frame_capture_done) ? S_PUBLISH : S_IDLE;
         end
         S_PUBLISH: state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   // Pixel classification, run closing and best-run selection for this cycle
   always_comb begin
      pix         = row_buf[PIX_W-1:0];
      is_pupil    = (POLARITY != 0) ? (pix >= thr) : (pix <= thr);
      last_pix    = (pixel_idx == LAST_IDX);
      run_len_inc = run_len + ONE;
      start_ext   = (run_len == '0) ? pixel_idx : run_start;
      cl_len      = run_len;
      cl_start    = run_start;
      if (is_pupil) begin
         // An open run only closes here if this is the final pixel
         cl_len   = last_pix ? run_len_inc : '0;
         cl_start = start_ext;
      end
      rb_len_n   = row_best_len;
      rb_start_n = row_best_start;
      if (cl_len > row_best_len) begin
         rb_len_n   = cl_len;
         rb_start_n = cl_start;
      end
      frame_upd = (state == S_SCAN) && last_pix &&
                  (rb_len_n >= MIN_LEN) && (rb_len_n > frame_best_len);
      // Forward the final row's candidate when publishing straight from SCAN
      pub_len    = frame_upd ? rb_len_n   : frame_best_len;
      pub_start  = frame_upd ? rb_start_n : frame_best_start;
      pub_row    = frame_upd ? row_idx    : frame_best_row;
      pub_center = pub_start + ((pub_len - ONE) >> 1);
   end

   // Row capture, scan datapath, frame accumulators and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         row_buf                   <= '0;
         thr                       <= '0;
         pixel_idx                 <= '0;
         run_len                   <= '0;
         run_start                 <= '0;
         row_best_len              <= '0;
         row_best_start            <= '0;
         frame_best_len            <= '0;
         frame_best_start          <= '0;
         frame_best_row            <= '0;
         row_idx                   <= '0;
         pending                   <= 1'b0;
         row_ready                 <= 1'b1;
         result_valid              <= 1'b0;
         pupil_location_horizontal <= '0;
         pupil_location_vertical   <= '0;
         pupil_width               <= '0;
         pupil_found               <= 1'b0;
      end else begin
         row_ready    <= (state_n == S_IDLE);
         result_valid <= (state_n == S_PUBLISH);

         case (state)
            S_IDLE: begin
               if (row_valid) begin
                  row_buf        <= row_pixels;
                  thr            <= threshold;
                  pixel_idx      <= '0;
                  run_len        <= '0;
                  run_start      <= '0;
                  row_best_len   <= '0;
                  row_best_start <= '0;
                  if (frame_capture_done) pending <= 1'b1;
               end
            end
            S_SCAN: begin
               row_buf        <= row_buf >> PIX_W;
               pixel_idx      <= pixel_idx + ONE;
               run_len        <= is_pupil ? run_len_inc : '0;
               run_start      <= start_ext;
               row_best_len   <= rb_len_n;
               row_best_start <= rb_start_n;
               if (frame_capture_done) pending <= 1'b1;
               if (last_pix) begin
                  if (frame_upd) begin
                     frame_best_len   <= rb_len_n;
                     frame_best_start <= rb_start_n;
                     frame_best_row   <= row_idx;
                  end
                  if (row_idx != ROW_MAX) row_idx <= row_idx + ONE;
               end
            end
            S_PUBLISH: begin
               frame_best_len   <= '0;
               frame_best_start <= '0;
               frame_best_row   <= '0;
               row_idx          <= '0;
               pending          <= 1'b0;
            end
            default: ;
         endcase

         // Results are loaded on entry to PUBLISH so they are visible during it
         if (state_n == S_PUBLISH) begin
            pupil_found               <= (pub_len != '0);
            pupil_width               <= pub_len;
            pupil_location_horizontal <= (pub_len != '0) ? pub_center : '0;
            pupil_location_vertical   <= (pub_len != '0) ? pub_row    : '0;
         end
      end
   end

endmodule

// File: doc/pupil_detect_param.md
Name: pupil_detect_param

Overview:
- Parametrised successor to the fixed 112-pixel pupil detector, in the SmartFusion Stonyman capture path downstream of the row buffer.
- Accepts one image row per valid/ready handshake and scans it at one pixel per clock for the longest contiguous run of pupil pixels.
- Tracks the widest run across the frame.
- On frame end, publishes the run centre (horizontal), row index (vertical), width and a found flag, with a one-cycle result strobe.

Parameters:
- RESOLUTION, 112, pixels per row.
- PIX_W, 8, bits per pixel.
- COORD_W, 8, width of coordinates, widths and row counter; must satisfy 2^COORD_W > RESOLUTION.
- POLARITY, 1, 1: pupil pixel if value >= threshold; 0: pupil pixel if value <= threshold.
- MIN_RUN, 4, minimum run length that counts as a pupil candidate.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- row_pixels  in  RESOLUTION*PIX_W  one row; pixel i = row_pixels[i*PIX_W +: PIX_W], pixel 0 at the LSB.
- row_valid  in  1  row_pixels is valid.
- row_ready  out  1  block can accept a row.
- frame_capture_done  in  1  one-cycle pulse marking the end of the frame.
- threshold  in  PIX_W  pixel classification threshold; sampled when a row is accepted.
- pupil_location_horizontal  out  COORD_W  centre column of the widest run.
- pupil_location_vertical  out  COORD_W  row index of the widest run.
- pupil_width  out  COORD_W  length of the widest run.
- pupil_found  out  1  a run of length >= MIN_RUN existed in the frame.
- result_valid  out  1  one-cycle strobe when the outputs update.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0 except row_ready=1.
  - State IDLE; row index, accumulators and pending flag cleared.
  - Reset mid-scan discards the partial row and the partial frame.
- States: IDLE, SCAN, PUBLISH.
- IDLE:
  - row_ready=1.
  - row_valid=1 latches row_pixels and threshold, clears the per-row run state, sets pixel_idx=0 and goes to SCAN.
  - frame_capture_done=1 with row_valid=0 goes to PUBLISH.
  - Both asserted in the same cycle: the row is accepted into the current frame, the frame end is held pending, and PUBLISH follows that row's scan.
- SCAN:
  - row_ready=0; row_valid is ignored and nothing is captured.
  - Exactly RESOLUTION cycles, one pixel per cycle.
  - Pupil pixel extends the current run (run_start = pixel_idx on the first pixel of a run).
  - Non-pupil pixel closes the run; the closed run replaces the row best only if strictly longer, so the earliest run wins ties.
  - A run still open at pixel RESOLUTION-1 closes on that pixel.
  - After the last pixel:
    - If row_best_len >= MIN_RUN and row_best_len > frame_best_len, latch frame_best (start, len, row index). Strictly greater, so the earliest row wins ties.
    - Increment the row index, saturating at 2^COORD_W-1.
    - Go to PUBLISH if a frame end is pending, otherwise IDLE.
  - frame_capture_done during SCAN sets the pending flag; the current row is included in the frame.
- PUBLISH (one cycle):
  - Registered outputs update:
    - horizontal = start + ((len-1)>>1)
    - vertical = row index
    - width = len
    - pupil_found = (len != 0)
  - If no candidate exists: horizontal, vertical and width are 0 and pupil_found=0.
  - result_valid=1 in this cycle only.
  - Frame accumulators, row index and pending flag clear; next state IDLE; row_ready=0 in this cycle.
- Outputs hold their values between PUBLISH cycles.
- Latency:
  - Row accepted at cycle t.
  - Scan occupies t+1 .. t+RESOLUTION.
  - result_valid asserts at t+RESOLUTION+1 when the frame end is pending.
  - Row throughput is one row per RESOLUTION+1 cycles.
- Arithmetic:
  - Run length counter is COORD_W bits and cannot overflow given the parameter constraint.
  - Centre computation is done at COORD_W width with no rounding up.

Test Plan:
- Reset: hold reset=0 for 10 clocks, release -> all outputs 0, row_ready=1, result_valid never asserts without frame_capture_done.
- Frame of 3 rows (threshold 0x80, POLARITY=1): row0 pixels 50..61=0xFF, row1 40..79=0xFF, row2 45..69=0xFF, others 0; then frame_capture_done -> single result_valid pulse with horizontal=59, vertical=1, width=40, pupil_found=1.
- Row-level ties and edges:
  - Row with runs 10..14 and 20..39 -> width=20, horizontal=29.
  - Row with a run at 100..111 touching the last pixel -> width=12, horizontal=105.
  - Equal 20-wide runs in rows 2 and 5 -> vertical=2.
- No pupil: all-zero frame, or rows with runs of length 3 only -> pupil_found=0, horizontal=vertical=width=0, result_valid pulses once.
- Handshake:
  - row_valid held high during SCAN -> no extra rows accepted, row_ready=0 for 112 cycles.
  - frame_capture_done mid-scan -> result_valid exactly at accept+113 and includes that row.
  - Simultaneous row_valid and frame_capture_done in IDLE -> row counted, then publish.
- Reset mid-operation: reset=0 at cycle 50 of a scan -> outputs 0 immediately; the next frame (single row, run 0..9) reports vertical=0, horizontal=4, width=10.
